// File: rtl/axi4lite_mem_arbiter.sv
// Shares one AXI4-lite memory port between instruction fetch (m0, read-only) and the LSU (m1, read+write).
// Reads are round-robin arbitrated with one outstanding transaction; writes from m1 use an independent FSM.
module axi4lite_mem_arbiter #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch master
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    input  logic              m0_rready,
    // load/store master
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    input  logic              m1_rready,
    input  logic              m1_awvalid,
    input  logic [ADDR_W-1:0] m1_awaddr,
    output logic              m1_awready,
    input  logic              m1_wvalid,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_wready,
    output logic              m1_bvalid,
    output logic [1:0]        m1_bresp,
    input  logic              m1_bready,
    // system bus
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    output logic              s_rready,
    output logic              s_awvalid,
    output logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awready,
    output logic              s_wvalid,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_wready,
    input  logic              s_bvalid,
    input  logic [1:0]        s_bresp,
    output logic              s_bready
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_REQ  = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [1:0]        rd_state_q, rd_state_d;
    logic              rd_owner_q, rd_owner_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;

    logic [1:0]        wr_state_q, wr_state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;

    logic grant_m0, grant_m1;
    logic rd_idle, rd_data;
    logic r_hs, aw_hs, w_hs, b_hs;
    logic wr_accept;

    // Owner/last_grant encoding: 0 = m0 (ifetch), 1 = m1 (LSU).
    assign rd_idle  = (rd_state_q == R_IDLE);
    assign rd_data  = (rd_state_q == R_DATA);
    // On a tie the master that did not win last time gets the bus, so neither starves.
    assign grant_m0 = rst_n && rd_idle && m0_arvalid && (!m1_arvalid || last_grant_q);
    assign grant_m1 = rst_n && rd_idle && m1_arvalid && (!m0_arvalid || !last_grant_q);
    assign r_hs     = rd_data && s_rvalid && s_rready;

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_owner_d   = rd_owner_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (grant_m0) begin
                    rd_owner_d = 1'b0;
                    araddr_d   = m0_araddr;
                    rd_state_d = R_ADDR;
                end else if (grant_m1) begin
                    rd_owner_d = 1'b1;
                    araddr_d   = m1_araddr;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (s_arready) rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    last_grant_d = rd_owner_q;
                    rd_state_d   = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        m0_arready = grant_m0;
        m1_arready = grant_m1;
        s_arvalid  = (rd_state_q == R_ADDR);
        s_araddr   = araddr_q;
        s_rready   = rd_data && (rd_owner_q ? m1_rready : m0_rready);
        m0_rvalid  = rd_data && !rd_owner_q && s_rvalid;
        m1_rvalid  = rd_data && rd_owner_q && s_rvalid;
        m0_rdata   = (rd_data && !rd_owner_q) ? s_rdata : '0;
        m1_rdata   = (rd_data && rd_owner_q) ? s_rdata : '0;
        m0_rresp   = (rd_data && !rd_owner_q) ? s_rresp : 2'b00;
        m1_rresp   = (rd_data && rd_owner_q) ? s_rresp : 2'b00;
    end

    // Write path accepts address and data together, then issues AW and W independently.
    assign wr_accept = rst_n && (wr_state_q == W_IDLE) && m1_awvalid && m1_wvalid;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign b_hs      = (wr_state_q == W_RESP) && s_bvalid && s_bready;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_accept) begin
                    awaddr_d   = m1_awaddr;
                    wdata_d    = m1_wdata;
                    wstrb_d    = m1_wstrb;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_RESP;
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                end
            end
            W_RESP: begin
                if (b_hs) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        m1_awready = wr_accept;
        m1_wready  = wr_accept;
        s_awvalid  = (wr_state_q == W_REQ) && !aw_done_q;
        s_wvalid   = (wr_state_q == W_REQ) && !w_done_q;
        s_awaddr   = awaddr_q;
        s_wdata    = wdata_q;
        s_wstrb    = wstrb_q;
        s_bready   = (wr_state_q == W_RESP) && m1_bready;
        m1_bvalid  = (wr_state_q == W_RESP) && s_bvalid;
        m1_bresp   = (wr_state_q == W_RESP) ? s_bresp : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q   <= R_IDLE;
            rd_owner_q   <= 1'b0;
            last_grant_q <= 1'b1;
            araddr_q     <= '0;
            wr_state_q   <= W_IDLE;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            rd_state_q   <= rd_state_d;
            rd_owner_q   <= rd_owner_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            wr_state_q   <= wr_state_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_mem_arbiter.sv
// Directed bench for axi4lite_mem_arbiter: idle-state arbitration table plus multi-cycle read/write sequences.
module tb_axi4lite_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_arvalid, m0_rready, m0_arready, m0_rvalid;
    logic [31:0] m0_araddr, m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid, m1_rready, m1_arready, m1_rvalid;
    logic [31:0] m1_araddr, m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_awvalid, m1_wvalid, m1_bready, m1_awready, m1_wready, m1_bvalid;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [1:0]  m1_bresp;
    logic        s_arvalid, s_rready, s_arready, s_rvalid;
    logic [31:0] s_araddr, s_rdata;
    logic [1:0]  s_rresp;
    logic        s_awvalid, s_wvalid, s_bready, s_awready, s_wready, s_bvalid;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;

    int checks = 0;
    int errors = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;

    always #5 clk = ~clk;

    axi4lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
    );

    always @(posedge clk) begin
        if (s_awvalid && s_awready) aw_cnt <= aw_cnt + 1;
        if (s_wvalid && s_wready) w_cnt <= w_cnt + 1;
    end

    typedef struct {
        logic m0_ar, m1_ar, aw, w;
        logic exp_m0_arready, exp_m1_arready, exp_wr_ready;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m0_arvalid = 0; m0_araddr = 0; m0_rready = 0;
        m1_arvalid = 0; m1_araddr = 0; m1_rready = 0;
        m1_awvalid = 0; m1_awaddr = 0; m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_bready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Plays the bus slave for one read; the caller keeps the owner's rready high.
    task automatic bus_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input int owner, input int delay);
        int n = 0;
        while (!s_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s_arvalid_seen", s_arvalid, 1);
        check("s_araddr", s_araddr, addr);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check("s_arvalid_hold", s_arvalid, 1);
            check("s_araddr_hold", s_araddr, addr);
        end
        s_arready = 1;
        @(posedge clk);
        @(negedge clk);
        s_arready = 0;
        check("s_arvalid_drop", s_arvalid, 0);
        s_rvalid = 1; s_rdata = data; s_rresp = resp;
        #1;
        check("s_rready", s_rready, 1);
        check("m0_rvalid", m0_rvalid, owner == 0);
        check("m1_rvalid", m1_rvalid, owner == 1);
        check("owner_rdata", (owner == 0) ? m0_rdata : m1_rdata, data);
        check("owner_rresp", (owner == 0) ? m0_rresp : m1_rresp, resp);
        @(posedge clk);
        @(negedge clk);
        s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int a0, w0;
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 1, 0, 0};
        vecs[2] = '{0, 1, 0, 0, 0, 1, 0};
        vecs[3] = '{1, 1, 0, 0, 1, 0, 0};
        vecs[4] = '{0, 0, 1, 0, 0, 0, 0};
        vecs[5] = '{0, 0, 0, 1, 0, 0, 0};
        vecs[6] = '{0, 0, 1, 1, 0, 0, 1};
        vecs[7] = '{1, 1, 1, 1, 1, 0, 1};

        rst_n = 0;
        clear_inputs();
        do_reset();

        // reset state
        #1;
        check("rst_s_arvalid", s_arvalid, 0);
        check("rst_s_awvalid", s_awvalid, 0);
        check("rst_s_wvalid", s_wvalid, 0);
        check("rst_s_araddr", s_araddr, 0);
        check("rst_s_awaddr", s_awaddr, 0);
        check("rst_m1_bvalid", m1_bvalid, 0);

        // idle-state arbitration table (inputs withdrawn before each rising edge)
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m0_arvalid = vecs[i].m0_ar; m1_arvalid = vecs[i].m1_ar;
            m1_awvalid = vecs[i].aw;    m1_wvalid  = vecs[i].w;
            #1;
            check($sformatf("vec%0d_m0_arready", i), m0_arready, vecs[i].exp_m0_arready);
            check($sformatf("vec%0d_m1_arready", i), m1_arready, vecs[i].exp_m1_arready);
            check($sformatf("vec%0d_m1_awready", i), m1_awready, vecs[i].exp_wr_ready);
            check($sformatf("vec%0d_m1_wready", i), m1_wready, vecs[i].exp_wr_ready);
            m0_arvalid = 0; m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
        end

        // single m0 read, bus accepts the address two cycles late
        @(negedge clk);
        m0_arvalid = 1; m0_araddr = 32'h100; m0_rready = 1;
        #1;
        check("s1_m0_arready", m0_arready, 1);
        check("s1_m1_arready", m1_arready, 0);
        @(posedge clk);
        @(negedge clk);
        m0_arvalid = 0;
        check("s1_m0_arready_busy", m0_arready, 0);
        bus_read(32'h100, 32'hDEADBEEF, 2'b00, 0, 2);
        check("s1_m0_rvalid_end", m0_rvalid, 0);

        // simultaneous requests right after reset: m0 first, then m1
        do_reset();
        m0_arvalid = 1; m0_araddr = 32'h1000; m0_rready = 1;
        m1_arvalid = 1; m1_araddr = 32'h2000; m1_rready = 1;
        #1;
        check("s2_m0_arready", m0_arready, 1);
        check("s2_m1_arready", m1_arready, 0);
        @(posedge clk);
        @(negedge clk);
        m0_arvalid = 0;
        check("s2_m1_arready_busy", m1_arready, 0);
        bus_read(32'h1000, 32'h11111111, 2'b00, 0, 0);
        #1;
        check("s2_m1_arready", m1_arready, 1);
        check("s2_m0_arready_after", m0_arready, 0);
        @(posedge clk);
        @(negedge clk);
        m1_arvalid = 0;
        bus_read(32'h2000, 32'h22222222, 2'b00, 1, 0);

        // continuous requests from both: grants alternate m0,m1,...
        m0_arvalid = 1; m0_araddr = 32'h3000;
        m1_arvalid = 1; m1_araddr = 32'h4000;
        for (int i = 0; i < 6; i++) begin
            int owner;
            owner = i % 2;
            #1;
            check($sformatf("s3_grant%0d_m0", i), m0_arready, owner == 0);
            check($sformatf("s3_grant%0d_m1", i), m1_arready, owner == 1);
            @(posedge clk);
            @(negedge clk);
            bus_read((owner == 1) ? 32'h4000 : 32'h3000, 32'hA0 + i, 2'b00, owner, 0);
        end
        m0_arvalid = 0; m1_arvalid = 0;

        // m1 write, s_wready three cycles after s_awready
        a0 = aw_cnt; w0 = w_cnt;
        @(negedge clk);
        m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h40; m1_wdata = 32'h12345678;
        m1_wstrb = 4'hF; m1_bready = 1;
        #1;
        check("s4_m1_awready", m1_awready, 1);
        check("s4_m1_wready", m1_wready, 1);
        @(posedge clk);
        @(negedge clk);
        m1_awvalid = 0; m1_wvalid = 0;
        check("s4_s_awvalid", s_awvalid, 1);
        check("s4_s_wvalid", s_wvalid, 1);
        check("s4_s_awaddr", s_awaddr, 32'h40);
        check("s4_s_wdata", s_wdata, 32'h12345678);
        check("s4_s_wstrb", s_wstrb, 4'hF);
        check("s4_m1_awready_busy", m1_awready, 0);
        s_awready = 1;
        @(posedge clk);
        @(negedge clk);
        s_awready = 0;
        for (int k = 0; k < 2; k++) begin
            check("s4_awvalid_dropped", s_awvalid, 0);
            check("s4_wvalid_held", s_wvalid, 1);
            @(negedge clk);
        end
        s_wready = 1;
        @(posedge clk);
        @(negedge clk);
        s_wready = 0;
        check("s4_wvalid_dropped", s_wvalid, 0);
        check("s4_awvalid_idle", s_awvalid, 0);
        check("s4_s_bready", s_bready, 1);
        check("s4_m1_bvalid_wait", m1_bvalid, 0);
        s_bvalid = 1; s_bresp = 2'b00;
        #1;
        check("s4_m1_bvalid", m1_bvalid, 1);
        check("s4_m1_bresp", m1_bresp, 2'b00);
        @(posedge clk);
        @(negedge clk);
        s_bvalid = 0;
        check("s4_m1_bvalid_end", m1_bvalid, 0);
        check("s4_aw_count", aw_cnt - a0, 1);
        check("s4_w_count", w_cnt - w0, 1);

        // overlapping m1 read (SLVERR) and write
        a0 = aw_cnt; w0 = w_cnt;
        m1_arvalid = 1; m1_araddr = 32'h80; m1_rready = 1;
        m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h44; m1_wdata = 32'hCAFEF00D;
        m1_wstrb = 4'h3; m1_bready = 1;
        #1;
        check("s5_m1_arready", m1_arready, 1);
        check("s5_m1_awready", m1_awready, 1);
        @(posedge clk);
        @(negedge clk);
        m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
        check("s5_s_arvalid", s_arvalid, 1);
        check("s5_s_araddr", s_araddr, 32'h80);
        check("s5_s_awvalid", s_awvalid, 1);
        check("s5_s_awaddr", s_awaddr, 32'h44);
        check("s5_s_wstrb", s_wstrb, 4'h3);
        s_arready = 1; s_awready = 1; s_wready = 1;
        @(posedge clk);
        @(negedge clk);
        s_arready = 0; s_awready = 0; s_wready = 0;
        s_rvalid = 1; s_rdata = 32'h55AA55AA; s_rresp = 2'b10;
        s_bvalid = 1; s_bresp = 2'b00;
        #1;
        check("s5_m1_rvalid", m1_rvalid, 1);
        check("s5_m1_rresp", m1_rresp, 2'b10);
        check("s5_m1_rdata", m1_rdata, 32'h55AA55AA);
        check("s5_m0_rvalid", m0_rvalid, 0);
        check("s5_m1_bvalid", m1_bvalid, 1);
        check("s5_m1_bresp", m1_bresp, 2'b00);
        @(posedge clk);
        @(negedge clk);
        s_rvalid = 0; s_rresp = 0; s_bvalid = 0;
        check("s5_m1_rvalid_end", m1_rvalid, 0);
        check("s5_m1_bvalid_end", m1_bvalid, 0);
        check("s5_aw_count", aw_cnt - a0, 1);
        check("s5_w_count", w_cnt - w0, 1);

        // reset while in R_DATA (write in flight); last_grant left at m0 beforehand
        m0_arvalid = 1; m0_araddr = 32'h500; m0_rready = 1;
        @(posedge clk);
        @(negedge clk);
        m0_arvalid = 0;
        bus_read(32'h500, 32'h0BADF00D, 2'b00, 0, 0);
        m0_arvalid = 1; m0_araddr = 32'h600; m0_rready = 0;
        m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h48; m1_wdata = 32'h1; m1_wstrb = 4'h1;
        @(posedge clk);
        @(negedge clk);
        m0_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
        s_arready = 1;
        @(posedge clk);
        @(negedge clk);
        s_arready = 0;
        s_rvalid = 1; s_rdata = 32'h77;
        #1;
        check("s6_m0_rvalid_pre", m0_rvalid, 1);
        check("s6_s_awvalid_pre", s_awvalid, 1);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        check("s6_m0_rvalid", m0_rvalid, 0);
        check("s6_m1_rvalid", m1_rvalid, 0);
        check("s6_s_rready", s_rready, 0);
        check("s6_s_arvalid", s_arvalid, 0);
        check("s6_s_awvalid", s_awvalid, 0);
        check("s6_s_wvalid", s_wvalid, 0);
        check("s6_s_bready", s_bready, 0);
        check("s6_m1_bvalid", m1_bvalid, 0);
        check("s6_s_araddr", s_araddr, 0);
        check("s6_s_awaddr", s_awaddr, 0);
        rst_n = 1; s_rvalid = 0; s_rdata = 0;
        m0_arvalid = 1; m1_arvalid = 1;
        #1;
        check("s6_m0_arready_lg", m0_arready, 1);
        check("s6_m1_arready_lg", m1_arready, 0);
        m0_arvalid = 0; m1_arvalid = 0;
        @(posedge clk);
        @(negedge clk);
        check("s6_s_arvalid_idle", s_arvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
